// File: rtl/button_midi_frontend.sv
// rtl/button_midi_frontend.sv - debounced buttons, MIDI UART receiver and message assembler
module button_midi_frontend #(
  parameter int BIT_CLKS     = 3200,
  parameter int DEBOUNCE_CNT = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       board_btn,
  input  logic       midi_rx,
  input  logic       btn2_pin_1,
  input  logic       btn2_pin_2,
  input  logic       btn3_pin_1,
  input  logic       btn3_pin_2,
  input  logic       btn4_pin_1,
  input  logic       btn4_pin_2,
  input  logic       btn5_pin_1,
  input  logic       btn5_pin_2,
  output logic [7:0] status_in,
  output logic [7:0] data1_in,
  output logic [7:0] data2_in,
  output logic [1:0] bytes_cnt_in,
  output logic       cmd_completed,
  output logic [1:0] midi_in_state,
  output logic       save_mode,
  output logic [2:0] btn_index,
  output logic       rx_busy
);

  localparam int CW = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] TAIL_M1 = CW'(BIT_CLKS / 2 - 2);
  // Pin order: board_btn, midi_rx, pin_1 of 2..5, pin_2 of 2..5; reset to idle levels.
  localparam logic [9:0] SYNC_INIT = 10'b0000_1111_11;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_TAIL} rx_state_t;

  logic [9:0] raw_pins;
  logic [9:0] sync1_q, sync2_q;
  logic [4:0] db_in, db_q, db_d, db_prev_q;
  logic [4:0][DEBOUNCE_CNT-1:0] db_cnt_q, db_cnt_d;
  logic [3:0] fs_rise;
  logic       board_fall;
  logic       rx_s, rx_prev_q;

  rx_state_t  rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_ok, frame_err;

  logic       msg_active_q, msg_active_d;
  logic       msg_got_q, msg_got_d;
  logic [7:0] msg_status_q, msg_status_d;
  logic [7:0] msg_d1_q, msg_d1_d;
  logic [7:0] status_q, status_d, data1_q, data1_d, data2_q, data2_d;
  logic [1:0] bytes_cnt_q, bytes_cnt_d;
  logic       cmd_completed_q, cmd_completed_d;
  logic       assigned_q, assigned_d, assigned_prev_q;
  logic       save_mode_q, save_mode_d;
  logic [2:0] btn_index_q, btn_index_d;

  assign raw_pins = {btn5_pin_2, btn4_pin_2, btn3_pin_2, btn2_pin_2,
                     btn5_pin_1, btn4_pin_1, btn3_pin_1, btn2_pin_1, midi_rx, board_btn};
  assign rx_s  = sync2_q[1];
  assign db_in = {~sync2_q[5:2] & sync2_q[9:6], sync2_q[0]};

  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (db_in[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (&db_cnt_q[i]) begin
        db_d[i]     = db_in[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign fs_rise    = db_q[4:1] & ~db_prev_q[4:1];
  assign board_fall = ~db_q[0] & db_prev_q[0];

  always_comb begin
    btn_index_d = 3'd0;
    if (fs_rise[0])      btn_index_d = 3'd1;
    else if (fs_rise[1]) btn_index_d = 3'd2;
    else if (fs_rise[2]) btn_index_d = 3'd3;
    else if (fs_rise[3]) btn_index_d = 3'd4;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_ok    = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          bit_idx_d  = 3'd0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d  = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          byte_ok    = rx_s;
          frame_err  = ~rx_s;
          rx_state_d = RX_TAIL;
        end
      end
      RX_TAIL: begin
        // Hold busy through the second half of the stop bit.
        if (rx_cnt_q == TAIL_M1) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    msg_active_d    = msg_active_q;
    msg_got_d       = msg_got_q;
    msg_status_d    = msg_status_q;
    msg_d1_d        = msg_d1_q;
    status_d        = status_q;
    data1_d         = data1_q;
    data2_d         = data2_q;
    bytes_cnt_d     = bytes_cnt_q;
    cmd_completed_d = cmd_completed_q;
    if (frame_err) begin
      msg_active_d = 1'b0;
    end else if (byte_ok && shift_q < 8'hF8) begin
      if (shift_q >= 8'hF0) begin
        msg_active_d    = 1'b0;
        cmd_completed_d = 1'b0;
      end else if (shift_q[7]) begin
        msg_active_d    = 1'b1;
        msg_got_d       = 1'b0;
        msg_status_d    = shift_q;
        cmd_completed_d = 1'b0;
      end else if (msg_active_q) begin
        if (msg_status_q[7:5] == 3'b110) begin
          status_d        = msg_status_q;
          data1_d         = shift_q;
          data2_d         = 8'h00;
          bytes_cnt_d     = 2'd2;
          cmd_completed_d = 1'b1;
          msg_active_d    = 1'b0;
        end else if (!msg_got_q) begin
          msg_d1_d  = shift_q;
          msg_got_d = 1'b1;
        end else begin
          status_d        = msg_status_q;
          data1_d         = msg_d1_q;
          data2_d         = shift_q;
          bytes_cnt_d     = 2'd3;
          cmd_completed_d = 1'b1;
          msg_active_d    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    assigned_d = assigned_q;
    if (!cmd_completed_q) assigned_d = 1'b0;
    else if (!assigned_q && save_mode_q && btn_index_q != 3'd0) assigned_d = 1'b1;
    save_mode_d = save_mode_q ^ board_fall;
    if (assigned_q && !assigned_prev_q) save_mode_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q         <= SYNC_INIT;
      sync2_q         <= SYNC_INIT;
      db_q            <= 5'b00001;
      db_prev_q       <= 5'b00001;
      db_cnt_q        <= '0;
      rx_prev_q       <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      msg_active_q    <= 1'b0;
      msg_got_q       <= 1'b0;
      msg_status_q    <= 8'h00;
      msg_d1_q        <= 8'h00;
      status_q        <= 8'h00;
      data1_q         <= 8'h00;
      data2_q         <= 8'h00;
      bytes_cnt_q     <= 2'd0;
      cmd_completed_q <= 1'b0;
      assigned_q      <= 1'b0;
      assigned_prev_q <= 1'b0;
      save_mode_q     <= 1'b0;
      btn_index_q     <= 3'd0;
    end else begin
      sync1_q         <= raw_pins;
      sync2_q         <= sync1_q;
      db_q            <= db_d;
      db_prev_q       <= db_q;
      db_cnt_q        <= db_cnt_d;
      rx_prev_q       <= rx_s;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      msg_active_q    <= msg_active_d;
      msg_got_q       <= msg_got_d;
      msg_status_q    <= msg_status_d;
      msg_d1_q        <= msg_d1_d;
      status_q        <= status_d;
      data1_q         <= data1_d;
      data2_q         <= data2_d;
      bytes_cnt_q     <= bytes_cnt_d;
      cmd_completed_q <= cmd_completed_d;
      assigned_q      <= assigned_d;
      assigned_prev_q <= assigned_q;
      save_mode_q     <= save_mode_d;
      btn_index_q     <= btn_index_d;
    end
  end

  assign status_in     = status_q;
  assign data1_in      = data1_q;
  assign data2_in      = data2_q;
  assign bytes_cnt_in  = bytes_cnt_q;
  assign cmd_completed = cmd_completed_q;
  assign midi_in_state = !cmd_completed_q ? 2'd0 : (assigned_q ? 2'd2 : 2'd1);
  assign save_mode     = save_mode_q;
  assign btn_index     = btn_index_q;
  assign rx_busy       = (rx_state_q != RX_IDLE);

endmodule

// File: tb/tb_button_midi_frontend.sv
// tb/tb_button_midi_frontend.sv - directed bench for button_midi_frontend
module tb_button_midi_frontend;

  localparam int BC = 16;

  logic clk = 1'b0;
  logic rst;
  logic board_btn, midi_rx;
  logic btn2_pin_1, btn2_pin_2, btn3_pin_1, btn3_pin_2;
  logic btn4_pin_1, btn4_pin_2, btn5_pin_1, btn5_pin_2;
  logic [7:0] status_in, data1_in, data2_in;
  logic [1:0] bytes_cnt_in, midi_in_state;
  logic       cmd_completed, save_mode, rx_busy;
  logic [2:0] btn_index;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  int save_toggles = 0;
  logic [2:0] last_idx = 3'd0;
  logic save_prev = 1'b0;

  always #5 clk = ~clk;

  button_midi_frontend #(.BIT_CLKS(BC), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .board_btn(board_btn), .midi_rx(midi_rx),
    .btn2_pin_1(btn2_pin_1), .btn2_pin_2(btn2_pin_2),
    .btn3_pin_1(btn3_pin_1), .btn3_pin_2(btn3_pin_2),
    .btn4_pin_1(btn4_pin_1), .btn4_pin_2(btn4_pin_2),
    .btn5_pin_1(btn5_pin_1), .btn5_pin_2(btn5_pin_2),
    .status_in(status_in), .data1_in(data1_in), .data2_in(data2_in),
    .bytes_cnt_in(bytes_cnt_in), .cmd_completed(cmd_completed),
    .midi_in_state(midi_in_state), .save_mode(save_mode),
    .btn_index(btn_index), .rx_busy(rx_busy)
  );

  always @(negedge clk) begin
    if (btn_index != 3'd0) begin
      pulse_cnt = pulse_cnt + 1;
      last_idx  = btn_index;
    end
    if (save_mode != save_prev) save_toggles = save_toggles + 1;
    save_prev = save_mode;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    midi_rx = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      tick(BC);
    end
    midi_rx = stop_bit;
    tick(BC);
    midi_rx = 1'b1;
    tick(2 * BC);
  endtask

  initial begin
    rst = 1'b0;
    board_btn = 1'b1; midi_rx = 1'b1;
    btn2_pin_1 = 1'b1; btn2_pin_2 = 1'b0; btn3_pin_1 = 1'b1; btn3_pin_2 = 1'b0;
    btn4_pin_1 = 1'b1; btn4_pin_2 = 1'b0; btn5_pin_1 = 1'b1; btn5_pin_2 = 1'b0;
    tick(3);
    check("rst_status", 32'(status_in), 32'h0);
    check("rst_cmd", 32'(cmd_completed), 32'h0);
    check("rst_save", 32'(save_mode), 32'h0);
    check("rst_state", 32'(midi_in_state), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    rst = 1'b1;
    tick(12);

    board_btn = 1'b0; tick(5);
    board_btn = 1'b1; tick(2);
    board_btn = 1'b0; tick(7);
    check("save_early", 32'(save_mode), 32'h0);
    tick(5);
    check("save_set", 32'(save_mode), 32'h1);
    board_btn = 1'b1; tick(15);
    check("save_toggles", 32'(save_toggles), 32'h1);

    send_byte(8'hB0, 1'b1); send_byte(8'h2E, 1'b1); send_byte(8'h7F, 1'b1);
    check("cc_cmd", 32'(cmd_completed), 32'h1);
    check("cc_status", 32'(status_in), 32'hB0);
    check("cc_d1", 32'(data1_in), 32'h2E);
    check("cc_d2", 32'(data2_in), 32'h7F);
    check("cc_cnt", 32'(bytes_cnt_in), 32'h3);
    check("cc_state", 32'(midi_in_state), 32'h1);

    send_byte(8'hC0, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h42, 1'b1);
    check("pc_status", 32'(status_in), 32'hC0);
    check("pc_d1", 32'(data1_in), 32'h42);
    check("pc_d2", 32'(data2_in), 32'h0);
    check("pc_cnt", 32'(bytes_cnt_in), 32'h2);
    check("pc_cmd", 32'(cmd_completed), 32'h1);

    pulse_cnt = 0;
    btn3_pin_1 = 1'b0; btn3_pin_2 = 1'b1;
    tick(20);
    check("fs3_pulses", 32'(pulse_cnt), 32'h1);
    check("fs3_idx", 32'(last_idx), 32'h2);
    check("fs3_state", 32'(midi_in_state), 32'h2);
    check("fs3_save", 32'(save_mode), 32'h0);
    btn3_pin_1 = 1'b1; btn3_pin_2 = 1'b0;
    tick(20);
    check("fs3_release", 32'(pulse_cnt), 32'h1);

    send_byte(8'h90, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'hF0, 1'b1);
    send_byte(8'h20, 1'b1); send_byte(8'h30, 1'b1);
    check("sysex_cmd", 32'(cmd_completed), 32'h0);
    check("sysex_state", 32'(midi_in_state), 32'h0);

    send_byte(8'h90, 1'b1); send_byte(8'h40, 1'b0); send_byte(8'h41, 1'b1);
    check("ferr_cmd", 32'(cmd_completed), 32'h0);
    send_byte(8'hC0, 1'b1); send_byte(8'h43, 1'b1);
    check("ferr_after_cmd", 32'(cmd_completed), 32'h1);
    check("ferr_after_status", 32'(status_in), 32'hC0);
    check("ferr_after_d1", 32'(data1_in), 32'h43);
    check("ferr_after_cnt", 32'(bytes_cnt_in), 32'h2);
    check("ferr_after_state", 32'(midi_in_state), 32'h1);

    pulse_cnt = 0;
    btn2_pin_1 = 1'b0; btn2_pin_2 = 1'b1; btn4_pin_1 = 1'b0; btn4_pin_2 = 1'b1;
    tick(20);
    check("dual_pulses", 32'(pulse_cnt), 32'h1);
    check("dual_idx", 32'(last_idx), 32'h1);
    check("dual_state", 32'(midi_in_state), 32'h1);

    midi_rx = 1'b0;
    tick(BC + 4);
    check("mid_busy", 32'(rx_busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_status", 32'(status_in), 32'h0);
    check("async_d1", 32'(data1_in), 32'h0);
    check("async_cnt", 32'(bytes_cnt_in), 32'h0);
    check("async_cmd", 32'(cmd_completed), 32'h0);
    check("async_state", 32'(midi_in_state), 32'h0);
    check("async_busy", 32'(rx_busy), 32'h0);
    check("async_btn", 32'(btn_index), 32'h0);
    check("async_save", 32'(save_mode), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_midi_frontend.md
Name: button_midi_frontend

Overview:
- Front-end input block of the MIDI footswitch controller.
- Debounces the board mode button and four two-pin footswitches.
- Receives MIDI bytes (31250 baud UART) and assembles channel messages.
- Tracks learn/save mode and reports button presses to the command store and MIDI-out logic.

Parameters:
- BIT_CLKS, 3200: clk cycles per MIDI bit (100 MHz / 31250).
- DEBOUNCE_CNT, 21: debounce counter width; input must be stable for 2^DEBOUNCE_CNT cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- board_btn  in  1  mode button, active-low
- midi_rx  in  1  MIDI UART line, idle high
- btnN_pin_1  in  1  (N=2..5) footswitch N normally-open contact, active-low
- btnN_pin_2  in  1  (N=2..5) footswitch N normally-closed contact, high when pressed
- status_in  out  8  last complete status byte
- data1_in  out  8  first data byte (0 if none)
- data2_in  out  8  second data byte (0 if none)
- bytes_cnt_in  out  2  bytes in last message (1..3)
- cmd_completed  out  1  level: a complete message is held
- midi_in_state  out  2  0 idle, 1 message waiting for button, 2 message assigned
- save_mode  out  1  learn mode active
- btn_index  out  3  one-cycle pulse, 1..4 = footswitch 2..5 pressed, 0 = none
- rx_busy  out  1  receiver inside a byte frame

Behaviour:
- Reset (rst low, async): all outputs 0; debouncers read "released"; receiver idle; assigned flag 0.
- Input synchronisation: every pin passes a 2-FF synchroniser before use.
- Debounce, per input: debounced value follows raw input only after it has been stable for 2^DEBOUNCE_CNT consecutive clk cycles. Any change restarts the count.
- Footswitch N "pressed" raw condition: pin_1==0 AND pin_2==1. This term is debounced.
- Press event: rising edge of a debounced footswitch press drives btn_index=N-1 for exactly one cycle.
  - Several edges in the same cycle: the lowest index wins; the others are dropped.
  - Release produces no event.
  - btn_index pulses regardless of save_mode.
- save_mode:
  - Toggles on each debounced board_btn press (falling edge).
  - Cleared in the cycle after midi_in_state==2 is first reached.
- UART receiver:
  - Start detection: falling edge on synchronised midi_rx while idle.
  - Sampling: start bit sampled at BIT_CLKS/2. If high, treat as a glitch and return to idle.
  - Data: 8 bits, LSB first, each sampled BIT_CLKS later.
  - Stop bit: sampled; if low, framing error, byte discarded and the current message aborted.
  - rx_busy is high from start detection to the end of the stop bit.
- Message assembly:
  - Byte >= 0xF8 (real-time) is ignored; the message in progress is not disturbed.
  - Byte 0xF0..0xF7: abort the message; ignore bytes until the next status byte.
  - Status 0x80..0xBF and 0xE0..0xEF need 2 data bytes (bytes_cnt_in=3).
  - Status 0xC0..0xDF needs 1 data byte (bytes_cnt_in=2; data2_in=0).
  - Data bytes (bit7=0) with no pending status are ignored. Running status is not supported.
  - New status mid-message: the partial message is discarded and the new message starts.
  - On completion: status_in, data1_in, data2_in and bytes_cnt_in update in the same cycle that cmd_completed is set.
  - Outputs hold until the next completion.
- cmd_completed: set on message completion; cleared when the next status byte is received, or by reset.
- midi_in_state (combinational from registers):
  - 0 when cmd_completed==0.
  - 1 when cmd_completed and assigned==0.
  - 2 when cmd_completed and assigned==1.
- Assigned flag:
  - Set when midi_in_state==1, save_mode==1 and btn_index!=0.
  - Cleared whenever midi_in_state==0.

Test Plan (use BIT_CLKS=16, DEBOUNCE_CNT=3):
- Bounce board_btn low for 5 cycles, then hold low 12 cycles -> save_mode toggles 0->1 exactly once, 8+ cycles after the stable low.
- Send 0xB0,0x2E,0x7F -> cmd_completed=1, status_in=0xB0, data1_in=0x2E, data2_in=0x7F, bytes_cnt_in=3, midi_in_state=1.
- Send 0xC0,0x42 with 0xF8 injected between the two bytes -> status_in=0xC0, data1_in=0x42, data2_in=0, bytes_cnt_in=2.
- save_mode=1, message held, press footswitch 3 (pin_1=0, pin_2=1) -> one-cycle btn_index=2, midi_in_state=2, then save_mode=0.
- Byte sent with stop bit low -> no completion, cmd_completed stays 0; a following valid 0xC0,0x43 completes normally.
- Footswitches 2 and 4 reach their debounced press in the same cycle -> single pulse btn_index=1; assert rst mid-frame -> all outputs 0 immediately.
